axil_master: RTL

//  Single-outstanding AXI4-Lite master (initiator) that converts a simple

---
 rtl/axil_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: accepts one command at a time, runs
// it as an AXI-Lite read or write and holds the captured response until consumed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// WR      | AW and W offered; each valid drops after its own handshake
// WR_RESP | bready high, waiting for the B beat
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for the R beat
// DONE    | resp_valid high with a stable response until resp_ready
module axil_master #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_resp,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;

    // Payloads come straight from the command registers, which only change in
    // IDLE, so they are stable for as long as any valid is high.
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_resp      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (cmd_we) begin
                            state          <= S_WR;
                            aw_done        <= 1'b0;
                            w_done         <= 1'b0;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                        end else begin
                            state          <= S_RD_ADDR;
                            m_axil_arvalid <= 1'b1;
                        end
                    end
                end

                S_WR: begin
                    if (aw_hs) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axil_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    // Either channel may complete first, or both in the same cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state         <= S_WR_RESP;
                        m_axil_bready <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        resp_resp     <= m_axil_bresp;
                        resp_rdata    <= '0;
                        resp_valid    <= 1'b1;
                        state         <= S_DONE;
                    end
                end

                S_RD_ADDR: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        resp_rdata    <= m_axil_rdata;
                        resp_resp     <= m_axil_rresp;
                        resp_valid    <= 1'b1;
                        state         <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
